hub75_row_capture: RTL and testbench

- Receive-side counterpart of led_display_driver_phy: samples the HUB75 pin bundle (R1/G1/B1/R2/G2/B2, BCLK, LAT, row address) and rebuilds each shifted row into parallel colour vectors.
- Each completed row is presented on a valid/ready interface with its address.
- Used in FPGA loopback self-test of the display path and as a synthesizable checker in driver testbenches.
- Runs in the display clock domain (clk20MHz); pins are oversampled, so BCLK high and low phases must each be ≥1 clk_in period.

---
 rtl/hub75_row_capture.sv | 124 ++++++++++++
 tb/tb_hub75_row_capture.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hub75_row_capture.sv
// Oversampled HUB75 receiver: rebuilds each shifted row and presents it on valid/ready.
// Row appears 2 clk_in edges after LAT pin rise; a good row arriving while the output is still unaccepted is dropped and flagged.
module hub75_row_capture #(
  parameter int NUM_COLS = 64,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk_in,
  input  logic                n_reset_in,
  input  logic                red_top_in,
  input  logic                green_top_in,
  input  logic                blue_top_in,
  input  logic                red_bot_in,
  input  logic                green_bot_in,
  input  logic                blue_bot_in,
  input  logic                bit_clk_in,
  input  logic                latch_in,
  input  logic [ADDR_W-1:0]   addr_in,
  output logic [NUM_COLS-1:0] row_red_top_out,
  output logic [NUM_COLS-1:0] row_green_top_out,
  output logic [NUM_COLS-1:0] row_blue_top_out,
  output logic [NUM_COLS-1:0] row_red_bot_out,
  output logic [NUM_COLS-1:0] row_green_bot_out,
  output logic [NUM_COLS-1:0] row_blue_bot_out,
  output logic [ADDR_W-1:0]   row_address_out,
  output logic                row_valid_out,
  input  logic                row_ready_in,
  output logic [CNT_W-1:0]    rows_captured_out,
  output logic                len_err_out,
  output logic                overrun_err_out,
  input  logic                err_clear_in
);

  localparam int CW = $clog2(NUM_COLS + 1);
  localparam int IW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [CW-1:0] COLS = CW'(NUM_COLS);

  logic [5:0]          data_q;
  logic                bclk_q, bclk_q2, lat_q, lat_q2;
  logic [ADDR_W-1:0]   addr_q;
  logic [CW-1:0]       col_cnt, cnt_nxt;
  logic                excess, excess_nxt;
  logic [NUM_COLS-1:0] sh [6];
  logic [NUM_COLS-1:0] sh_nxt [6];
  logic                bclk_rise, lat_rise, shift_en, good, bad, load, drop;

  // The bit shifted in the latch cycle must count toward that row, so the
  // latch decision looks at the post-shift view of the counter and vectors.
  always_comb begin
    bclk_rise  = bclk_q & ~bclk_q2;
    lat_rise   = lat_q & ~lat_q2;
    shift_en   = bclk_rise && (col_cnt != COLS);
    excess_nxt = excess | (bclk_rise && (col_cnt == COLS));
    cnt_nxt    = col_cnt + CW'(shift_en);
    for (int i = 0; i < 6; i++) begin
      sh_nxt[i] = sh[i];
      if (shift_en) sh_nxt[i][col_cnt[IW-1:0]] = data_q[i];
    end
    good = lat_rise && (cnt_nxt == COLS) && !excess_nxt;
    bad  = lat_rise && !((cnt_nxt == COLS) && !excess_nxt);
    load = good && (!row_valid_out || row_ready_in);
    drop = good && row_valid_out && !row_ready_in;
  end

  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      data_q            <= '0;
      bclk_q            <= 1'b0;
      bclk_q2           <= 1'b0;
      lat_q             <= 1'b0;
      lat_q2            <= 1'b0;
      addr_q            <= '0;
      col_cnt           <= '0;
      excess            <= 1'b0;
      for (int i = 0; i < 6; i++) sh[i] <= '0;
      row_red_top_out   <= '0;
      row_green_top_out <= '0;
      row_blue_top_out  <= '0;
      row_red_bot_out   <= '0;
      row_green_bot_out <= '0;
      row_blue_bot_out  <= '0;
      row_address_out   <= '0;
      row_valid_out     <= 1'b0;
      rows_captured_out <= '0;
      len_err_out       <= 1'b0;
      overrun_err_out   <= 1'b0;
    end else begin
      data_q  <= {blue_bot_in, green_bot_in, red_bot_in, blue_top_in, green_top_in, red_top_in};
      bclk_q  <= bit_clk_in;
      bclk_q2 <= bclk_q;
      lat_q   <= latch_in;
      lat_q2  <= lat_q;
      addr_q  <= addr_in;
      for (int i = 0; i < 6; i++) sh[i] <= sh_nxt[i];

      if (lat_rise) begin
        col_cnt <= '0;
        excess  <= 1'b0;
      end else begin
        col_cnt <= cnt_nxt;
        excess  <= excess_nxt;
      end

      if (load) begin
        row_red_top_out   <= sh_nxt[0];
        row_green_top_out <= sh_nxt[1];
        row_blue_top_out  <= sh_nxt[2];
        row_red_bot_out   <= sh_nxt[3];
        row_green_bot_out <= sh_nxt[4];
        row_blue_bot_out  <= sh_nxt[5];
        row_address_out   <= addr_q;
        row_valid_out     <= 1'b1;
        rows_captured_out <= rows_captured_out + 1'b1;
      end else if (row_valid_out && row_ready_in) begin
        row_valid_out <= 1'b0;
      end

      // Set events take priority over clear.
      len_err_out     <= (len_err_out & ~err_clear_in) | bad;
      overrun_err_out <= (overrun_err_out & ~err_clear_in) | drop;
    end
  end

endmodule

// File: tb/tb_hub75_row_capture.sv
// Directed bench for hub75_row_capture; counter width reduced to 4 to reach wrap.
module tb_hub75_row_capture;
  localparam int NC = 64;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic r1 = 0, g1 = 0, b1 = 0, r2 = 0, g2 = 0, b2 = 0;
  logic bclk = 0, lat = 0, ready = 0, err_clear = 0;
  logic [3:0] addr = '0;
  logic [NC-1:0] o_rt, o_gt, o_bt, o_rb, o_gb, o_bb;
  logic [3:0] o_addr, o_cnt;
  logic o_valid, o_len, o_ovr;

  int n_checks = 0;
  int n_fail = 0;

  always #25 clk = ~clk;

  hub75_row_capture #(.NUM_COLS(NC), .ADDR_W(4), .CNT_W(4)) dut (
    .clk_in(clk), .n_reset_in(n_reset),
    .red_top_in(r1), .green_top_in(g1), .blue_top_in(b1),
    .red_bot_in(r2), .green_bot_in(g2), .blue_bot_in(b2),
    .bit_clk_in(bclk), .latch_in(lat), .addr_in(addr),
    .row_red_top_out(o_rt), .row_green_top_out(o_gt), .row_blue_top_out(o_bt),
    .row_red_bot_out(o_rb), .row_green_bot_out(o_gb), .row_blue_bot_out(o_bb),
    .row_address_out(o_addr), .row_valid_out(o_valid), .row_ready_in(ready),
    .rows_captured_out(o_cnt), .len_err_out(o_len), .overrun_err_out(o_ovr),
    .err_clear_in(err_clear)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One BCLK pulse: one cycle high with data, then one cycle low.
  task automatic pulse(input logic [5:0] d);
    @(posedge clk); #2;
    {b2, g2, r2, b1, g1, r1} = d;
    bclk = 1'b1;
    @(posedge clk); #2;
    bclk = 1'b0;
  endtask

  task automatic shift_row(input logic [63:0] rt, gt, bt, rb, gb, bb, input int n);
    for (int k = 0; k < n; k++) begin
      if (k < NC) pulse({bb[k], gb[k], rb[k], bt[k], gt[k], rt[k]});
      else        pulse(6'h3F);
    end
  endtask

  // Returns at the negedge after the output update edge.
  task automatic do_latch(input logic [3:0] a);
    @(posedge clk); #2;
    lat = 1'b1; addr = a;
    @(posedge clk); #2;
    lat = 1'b0; addr = ~a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_errs();
    @(posedge clk); #2 err_clear = 1'b1;
    @(posedge clk); #2 err_clear = 1'b0;
    @(negedge clk);
  endtask

  logic [63:0] pat;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_rt", o_rt, 64'd0);
    check("reset_cnt", 64'(o_cnt), 64'd0);
    check("reset_errs", 64'({o_len, o_ovr}), 64'd0);
    #2 n_reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_valid", 64'(o_valid), 64'd0);

    // LAT with no BCLK
    do_latch(4'h3);
    check("nobclk_len_err", 64'(o_len), 64'd1);
    check("nobclk_valid", 64'(o_valid), 64'd0);
    clear_errs();
    check("len_err_cleared", 64'(o_len), 64'd0);

    // Parity row, ready high
    ready = 1'b1;
    shift_row(64'hAAAA_AAAA_AAAA_AAAA, '0, '0, '0, '0, '0, 64);
    do_latch(4'h5);
    check("par_valid", 64'(o_valid), 64'd1);
    check("par_rt", o_rt, 64'hAAAA_AAAA_AAAA_AAAA);
    check("par_others", o_gt | o_bt | o_rb | o_gb | o_bb, 64'd0);
    check("par_addr", 64'(o_addr), 64'd5);
    check("par_cnt", 64'(o_cnt), 64'd1);
    @(negedge clk);
    check("par_valid_drop", 64'(o_valid), 64'd0);

    // Overrun: row A held, row B dropped
    ready = 1'b0;
    shift_row(64'h1, '0, '0, '0, '0, 64'h8000_0000_0000_0000, 64);
    do_latch(4'h7);
    check("rowA_valid", 64'(o_valid), 64'd1);
    shift_row(64'h2, 64'hFF, '0, '0, '0, '0, 64);
    do_latch(4'h9);
    check("ovr_err", 64'(o_ovr), 64'd1);
    check("ovr_holds_rt", o_rt, 64'h1);
    check("ovr_holds_gt", o_gt, 64'd0);
    check("ovr_holds_bb", o_bb, 64'h8000_0000_0000_0000);
    check("ovr_holds_addr", 64'(o_addr), 64'd7);
    check("ovr_cnt", 64'(o_cnt), 64'd2);
    check("ovr_no_len_err", 64'(o_len), 64'd0);
    @(posedge clk); #2 ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_still", 64'(o_valid), 64'd1);
    @(negedge clk);
    check("ovr_valid_drop", 64'(o_valid), 64'd0);
    clear_errs();
    check("ovr_cleared", 64'(o_ovr), 64'd0);

    // Short and long rows
    shift_row('1, '0, '0, '0, '0, '0, 63);
    do_latch(4'h1);
    check("short_len_err", 64'(o_len), 64'd1);
    check("short_valid", 64'(o_valid), 64'd0);
    clear_errs();
    shift_row('1, '0, '0, '0, '0, '0, 65);
    do_latch(4'h2);
    check("long_len_err", 64'(o_len), 64'd1);
    check("long_valid", 64'(o_valid), 64'd0);
    clear_errs();
    shift_row(64'h0123_4567_89AB_CDEF, '0, '0, '0, '0, '0, 64);
    do_latch(4'hC);
    check("recover_valid", 64'(o_valid), 64'd1);
    check("recover_rt", o_rt, 64'h0123_4567_89AB_CDEF);
    check("recover_addr", 64'(o_addr), 64'd12);
    check("recover_cnt", 64'(o_cnt), 64'd3);
    check("recover_len_err", 64'(o_len), 64'd0);

    // 64th BCLK rise coincident with LAT rise
    shift_row('0, '0, '0, '0, '0, '0, 63);
    @(posedge clk); #2;
    {b2, g2, r2, b1, g1, r1} = 6'b100000;
    bclk = 1'b1; lat = 1'b1; addr = 4'hE;
    @(posedge clk); #2;
    bclk = 1'b0; lat = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("simul_valid", 64'(o_valid), 64'd1);
    check("simul_bb", o_bb, 64'h8000_0000_0000_0000);
    check("simul_addr", 64'(o_addr), 64'd14);
    check("simul_len_err", 64'(o_len), 64'd0);
    check("simul_cnt", 64'(o_cnt), 64'd4);

    // Address sweep through counter wrap (4 + 13 = 17 -> 1)
    for (int i = 0; i < 13; i++) begin
      pat = {16{4'(i)}};
      shift_row(pat, '0, '0, '0, '0, ~pat, 64);
      do_latch(4'(i));
      check("sweep_addr", 64'(o_addr), 64'(i));
      check("sweep_rt", o_rt, pat);
      check("sweep_bb", o_bb, ~pat);
      check("sweep_cnt", 64'(o_cnt), 64'((5 + i) % 16));
    end
    check("sweep_errs", 64'({o_len, o_ovr}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
